countdown_timer: RTL and testbench

- Loadable down-counting timer; the consumer/terminal-count counterpart of the free-running up counter.
- Software or control logic loads a period, starts it, and receives a single-cycle expiry pulse when the period elapses.
- Supports one-shot and periodic (auto-reload) modes, level pause, abort and retrigger.
- Sits beside the up counter in the timing/control path; its expire pulse feeds interrupt, timeout and strobe logic.

---
 rtl/countdown_timer.sv | 106 ++++++++++
 tb/tb_countdown_timer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot/periodic modes, pause, abort and retrigger.
// Emits a single-cycle expire pulse when the loaded period elapses.
module countdown_timer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             periodic,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             paused,
   output logic             expire
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] count_nx;
   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] reload_nx;
   logic             mode_reg;
   logic             mode_nx;
   logic             expire_nx;

   // State and registered outputs; busy/paused are derived from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         mode_reg   <= 1'b0;
         busy       <= 1'b0;
         paused     <= 1'b0;
         expire     <= 1'b0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         reload_reg <= reload_nx;
         mode_reg   <= mode_nx;
         busy       <= (state_nx != IDLE);
         paused     <= (state_nx == HOLD);
         expire     <= expire_nx;
      end
   end

   // Priority: abort > start > pause > decrement
   always_comb begin
      state_nx  = state;
      count_nx  = count;
      reload_nx = reload_reg;
      mode_nx   = mode_reg;
      expire_nx = 1'b0;

      if (abort) begin
         state_nx = IDLE;
         count_nx = '0;
      end else if (start) begin
         reload_nx = load_value;
         mode_nx   = periodic;
         if (load_value == '0) begin
            state_nx  = IDLE;
            count_nx  = '0;
            expire_nx = 1'b1;
         end else begin
            state_nx = RUN;
            count_nx = load_value;
         end
      end else begin
         unique case (state)
            RUN, HOLD: begin
               if (pause) begin
                  state_nx = HOLD;
               end else if (count == WIDTH'(1)) begin
                  expire_nx = 1'b1;
                  if (mode_reg) begin
                     state_nx = RUN;
                     count_nx = reload_reg;
                  end else begin
                     state_nx = IDLE;
                     count_nx = '0;
                  end
               end else if (count == '0) begin
                  // Unreachable in normal operation; park safely without wrapping
                  state_nx = IDLE;
               end else begin
                  state_nx = RUN;
                  count_nx = count - WIDTH'(1);
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a deadline-based reference model queues the
// expected outputs per edge; a monitor pops and compares them just after each edge.
module tb_countdown_timer;

   localparam int unsigned WIDTH = 32;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             periodic;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             paused;
   logic             expire;

   countdown_timer #(.WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_value (load_value),
      .start      (start),
      .periodic   (periodic),
      .pause      (pause),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .paused     (paused),
      .expire     (expire)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      longint unsigned  idx;
      logic [WIDTH-1:0] count;
      logic             busy;
      logic             paused;
      logic             expire;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: a running period is a deadline edge; holding pushes the deadline out
   longint unsigned t        = 0;
   bit              m_active = 1'b0;
   bit              m_held   = 1'b0;
   bit              m_mode   = 1'b0;
   longint unsigned m_period = 0;
   longint unsigned m_deadline = 0;

   task automatic step(input bit r, input logic [WIDTH-1:0] lv, input bit st,
                       input bit per, input bit pa, input bit ab);
      exp_t e;
      @(negedge clock);
      reset      = r;
      load_value = lv;
      start      = st;
      periodic   = per;
      pause      = pa;
      abort      = ab;
      t++;
      e.idx    = t;
      e.expire = 1'b0;
      if (r) begin
         m_active = 1'b0; m_held = 1'b0; m_mode = 1'b0; m_period = 0;
      end else if (ab) begin
         m_active = 1'b0; m_held = 1'b0;
      end else if (st) begin
         m_period = longint'(lv);
         m_mode   = per;
         m_held   = 1'b0;
         if (lv == '0) begin
            m_active = 1'b0;
            e.expire = 1'b1;
         end else begin
            m_active   = 1'b1;
            m_deadline = t + longint'(lv);
         end
      end else if (m_active && pa) begin
         m_held = 1'b1;
         m_deadline++;
      end else if (m_active) begin
         m_held = 1'b0;
         if (t == m_deadline) begin
            e.expire = 1'b1;
            if (m_mode) m_deadline = t + m_period;
            else        m_active   = 1'b0;
         end
      end
      e.count  = m_active ? WIDTH'(m_deadline - t) : '0;
      e.busy   = m_active;
      e.paused = m_held;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic go(input logic [WIDTH-1:0] lv, input bit per);
      step(1'b0, lv, 1'b1, per, 1'b0, 1'b0);
   endtask

   // Monitor: one expected entry per clock edge, compared 1 time unit after the edge
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (count !== e.count) begin
            failures++;
            $display("FAIL count edge=%0d got=%0h want=%0h", e.idx, count, e.count);
         end
         checks++;
         if (busy !== e.busy) begin
            failures++;
            $display("FAIL busy edge=%0d got=%0b want=%0b", e.idx, busy, e.busy);
         end
         checks++;
         if (paused !== e.paused) begin
            failures++;
            $display("FAIL paused edge=%0d got=%0b want=%0b", e.idx, paused, e.paused);
         end
         checks++;
         if (expire !== e.expire) begin
            failures++;
            $display("FAIL expire edge=%0d got=%0b want=%0b", e.idx, expire, e.expire);
         end
      end
   end

   initial begin
      #300000;
      failures++;
      $display("FAIL watchdog timeout pending=%0d want=0", exp_q.size());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      reset = 1'b1; load_value = '0; start = 1'b0;
      periodic = 1'b0; pause = 1'b0; abort = 1'b0;

      // Reset then one-shot of 5
      step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      go(32'd5, 1'b0);
      idle(7);

      // Periodic of 3 through three elapses, then abort
      go(32'd3, 1'b1);
      idle(9);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Pause for 3 cycles at count 2
      go(32'd4, 1'b0);
      idle(2);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);

      // Pause at the terminal count
      go(32'd2, 1'b0);
      idle(1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);

      // Abort at count 2
      go(32'd4, 1'b0);
      idle(2);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(5);

      // Retrigger at count 2 with a period of 6
      go(32'd5, 1'b0);
      idle(3);
      go(32'd6, 1'b0);
      idle(8);

      // Zero period in periodic mode
      go(32'd0, 1'b1);
      idle(3);

      // Abort together with start
      go(32'd3, 1'b0);
      idle(1);
      step(1'b0, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(3);

      // Start together with pause
      step(1'b0, 32'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(6);

      // Reset mid periodic run
      go(32'd5, 1'b1);
      idle(2);
      step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(6);

      // Maximum period
      go('1, 1'b1);
      idle(3);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int unsigned      sel;
         int unsigned      lsel;
         logic [WIDTH-1:0] lv;
         bit               r, ab, st, pa;
         sel  = $urandom_range(0, 999);
         lsel = $urandom_range(0, 19);
         if (lsel == 0)       lv = '0;
         else if (lsel == 19) lv = WIDTH'($urandom);
         else                 lv = WIDTH'($urandom_range(1, 12));
         r  = (sel < 5);
         ab = ($urandom_range(0, 99) < 3);
         st = ($urandom_range(0, 99) < 8);
         pa = ($urandom_range(0, 99) < 20);
         step(r, lv, st, 1'($urandom_range(0, 1)), pa, ab);
      end
      idle(2);

      @(posedge clock);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
